// File: rtl/pipe_delay_line_pkg.sv
// Shared constants and the occupancy-update helper for the pipe_delay_line family.
package pipe_delay_line_pkg;

  localparam int MAX_DEPTH     = 8;
  localparam int OCC_W         = 4;
  localparam int DEFAULT_WIDTH = 18;
  localparam int MAX_WIDTH     = 48;

  // What the occupancy counter does on an enabled shift.
  typedef enum logic [1:0] {
    OCC_HOLD = 2'd0,
    OCC_INC  = 2'd1,
    OCC_DEC  = 2'd2
  } occ_action_e;

  // A sample entering while another leaves nets to zero. The count is
  // saturated at both ends so it can never drift outside 0..maxOcc.
  function automatic occ_action_e occAction(
    input logic             inc,
    input logic             dec,
    input logic [OCC_W-1:0] occ,
    input logic [OCC_W-1:0] maxOcc
  );
    occ_action_e act;
    act = OCC_HOLD;
    if (inc && !dec && (occ < maxOcc)) begin
      act = OCC_INC;
    end else if (dec && !inc && (occ != '0)) begin
      act = OCC_DEC;
    end
    return act;
  endfunction

endpackage

// File: rtl/pipe_delay_line_stage.sv
// One pipeline stage: a plain register with async reset, clock enable and
// synchronous clear. The clear beats the enable.
module pipe_delay_stage #(
  parameter int           W      = 19,
  parameter logic [W-1:0] RSTVAL = '0
) (
  input  logic         CLK,
  input  logic         RSTIN,
  input  logic         i_ce,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Register with reset/clear to RSTVAL; advances only when enabled.
  always_ff @(posedge CLK or posedge RSTIN) begin
    if (RSTIN) begin
      r_q <= RSTVAL;
    end else if (i_clr) begin
      r_q <= RSTVAL;
    end else if (i_ce) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_delay_line.sv
// Parameterised delay line. Each stage carries the data word plus its valid
// bit; a separate saturating counter tracks how many valid samples are in
// flight. DEPTH=0 collapses to a pure wire.
module pipe_delay_line
  import pipe_delay_line_pkg::*;
#(
  parameter int               WIDTH  = DEFAULT_WIDTH,
  parameter int               DEPTH  = 1,
  parameter logic [WIDTH-1:0] RSTVAL = '0
) (
  input  logic             CLK,
  input  logic             RSTIN,
  input  logic             CEIN,
  input  logic             CLRIN,
  input  logic             VALID_IN,
  input  logic [WIDTH-1:0] IN,
  output logic [WIDTH-1:0] OUT,
  output logic             VALID_OUT,
  output logic [OCC_W-1:0] OCC,
  output logic             BUSY
);

  if ((DEPTH < 0) || (DEPTH > MAX_DEPTH)) begin : g_badDepth
    $error("pipe_delay_line: DEPTH must be within 0..8");
  end
  if ((WIDTH < 1) || (WIDTH > MAX_WIDTH)) begin : g_badWidth
    $error("pipe_delay_line: WIDTH must be within 1..48");
  end

  if (DEPTH == 0) begin : g_bypass
    // Control inputs are intentionally ignored in the unregistered build.
    logic w_unused;
    assign w_unused  = ^{CLK, RSTIN, CEIN, CLRIN};
    assign OUT       = IN;
    assign VALID_OUT = VALID_IN;
    assign OCC       = '0;
  end else begin : g_pipe
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    logic [WIDTH:0]   w_stageQ [DEPTH];
    logic [OCC_W-1:0] r_occ;
    occ_action_e      w_occAct;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic [WIDTH:0] w_d;
      if (k == 0) begin : g_head
        assign w_d = {VALID_IN, IN};
      end else begin : g_body
        assign w_d = w_stageQ[k-1];
      end

      pipe_delay_stage #(
        .W      (WIDTH + 1),
        .RSTVAL ({1'b0, RSTVAL})
      ) u_stage (
        .CLK   (CLK),
        .RSTIN (RSTIN),
        .i_ce  (CEIN),
        .i_clr (CLRIN),
        .i_d   (w_d),
        .o_q   (w_stageQ[k])
      );
    end

    assign {VALID_OUT, OUT} = w_stageQ[DEPTH-1];
    assign w_occAct = occAction(VALID_IN, VALID_OUT, r_occ, DEPTH_OCC);

    // Occupancy counter: follows samples entering and leaving on each enabled shift.
    always_ff @(posedge CLK or posedge RSTIN) begin
      if (RSTIN) begin
        r_occ <= '0;
      end else if (CLRIN) begin
        r_occ <= '0;
      end else if (CEIN) begin
        case (w_occAct)
          OCC_INC: r_occ <= r_occ + OCC_W'(1);
          OCC_DEC: r_occ <= r_occ - OCC_W'(1);
          default: r_occ <= r_occ;
        endcase
      end
    end

    assign OCC = r_occ;
  end

  assign BUSY = (OCC != '0);

endmodule

// File: tb/tb_pipe_delay_line.sv
// Directed testbench for pipe_delay_line. Several instances with different
// DEPTH/RSTVAL share one set of inputs; each scenario resets and then checks
// the instance it is about.
module tb_pipe_delay_line;

  logic        CLK;
  logic        rstIn;
  logic        ceIn;
  logic        clrIn;
  logic        validIn;
  logic [17:0] inData;

  logic [17:0] out3, out2, out4, out2r, out0, out8;
  logic        vo3, vo2, vo4, vo2r, vo0, vo8;
  logic [3:0]  occ3, occ2, occ4, occ2r, occ0, occ8;
  logic        busy3, busy2, busy4, busy2r, busy0, busy8;

  int errors = 0;
  int checks = 0;

  pipe_delay_line #(.WIDTH(18), .DEPTH(3), .RSTVAL(18'h00000)) u_d3 (
    .CLK(CLK), .RSTIN(rstIn), .CEIN(ceIn), .CLRIN(clrIn), .VALID_IN(validIn),
    .IN(inData), .OUT(out3), .VALID_OUT(vo3), .OCC(occ3), .BUSY(busy3));
  pipe_delay_line #(.WIDTH(18), .DEPTH(2), .RSTVAL(18'h00000)) u_d2 (
    .CLK(CLK), .RSTIN(rstIn), .CEIN(ceIn), .CLRIN(clrIn), .VALID_IN(validIn),
    .IN(inData), .OUT(out2), .VALID_OUT(vo2), .OCC(occ2), .BUSY(busy2));
  pipe_delay_line #(.WIDTH(18), .DEPTH(4), .RSTVAL(18'h15555)) u_d4 (
    .CLK(CLK), .RSTIN(rstIn), .CEIN(ceIn), .CLRIN(clrIn), .VALID_IN(validIn),
    .IN(inData), .OUT(out4), .VALID_OUT(vo4), .OCC(occ4), .BUSY(busy4));
  pipe_delay_line #(.WIDTH(18), .DEPTH(2), .RSTVAL(18'h3FFFF)) u_d2r (
    .CLK(CLK), .RSTIN(rstIn), .CEIN(ceIn), .CLRIN(clrIn), .VALID_IN(validIn),
    .IN(inData), .OUT(out2r), .VALID_OUT(vo2r), .OCC(occ2r), .BUSY(busy2r));
  pipe_delay_line #(.WIDTH(18), .DEPTH(0), .RSTVAL(18'h00000)) u_d0 (
    .CLK(CLK), .RSTIN(rstIn), .CEIN(ceIn), .CLRIN(clrIn), .VALID_IN(validIn),
    .IN(inData), .OUT(out0), .VALID_OUT(vo0), .OCC(occ0), .BUSY(busy0));
  pipe_delay_line #(.WIDTH(18), .DEPTH(8), .RSTVAL(18'h00000)) u_d8 (
    .CLK(CLK), .RSTIN(rstIn), .CEIN(ceIn), .CLRIN(clrIn), .VALID_IN(validIn),
    .IN(inData), .OUT(out8), .VALID_OUT(vo8), .OCC(occ8), .BUSY(busy8));

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Advance past the next rising edge and settle.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Short reset pulse placed between clock edges.
  task automatic resetAll();
    ceIn    = 1'b1;
    clrIn   = 1'b0;
    validIn = 1'b0;
    inData  = '0;
    rstIn   = 1'b1;
    #2;
    rstIn   = 1'b0;
  endtask

  // Reset values, visible before any clock edge.
  task automatic test_reset();
    rstIn = 1'b1; ceIn = 1'b1; clrIn = 1'b0; validIn = 1'b0; inData = '0;
    #2;
    checks++;
    if (out3 !== 18'h0 || vo3 !== 1'b0 || occ3 !== 4'd0 || busy3 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_d3: out=%h vo=%b occ=%0d busy=%b, want 0/0/0/0", out3, vo3, occ3, busy3);
    end
    checks++;
    if (out4 !== 18'h15555 || vo4 !== 1'b0 || occ4 !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_d4: out=%h vo=%b occ=%0d, want 15555/0/0", out4, vo4, occ4);
    end
    checks++;
    if (out2r !== 18'h3FFFF || busy2r !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_d2r: out=%h busy=%b, want 3ffff/0", out2r, busy2r);
    end
    step();
    rstIn = 1'b0;
  endtask

  // DEPTH=3: three valid samples, then idle; latency is three enabled edges.
  task automatic test_latency();
    logic [17:0] stimIn  [6] = '{18'h1, 18'h2, 18'h3, 18'h0, 18'h0, 18'h0};
    logic        stimVld [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [17:0] expOut  [6] = '{18'h0, 18'h0, 18'h1, 18'h2, 18'h3, 18'h0};
    logic        expVo   [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0]  expOcc  [6] = '{4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd0};
    resetAll();
    for (int i = 0; i < 6; i++) begin
      inData = stimIn[i]; validIn = stimVld[i];
      step();
      checks++;
      if (out3 !== expOut[i] || vo3 !== expVo[i] || occ3 !== expOcc[i] || busy3 !== (expOcc[i] != 0)) begin
        errors++;
        $display("[TB] FAIL latency edge%0d: out=%h vo=%b occ=%0d busy=%b, want %h/%b/%0d", i + 1,
                 out3, vo3, occ3, busy3, expOut[i], expVo[i], expOcc[i]);
      end
    end
  endtask

  // DEPTH=2: stall for four cycles mid-stream, then resume.
  task automatic test_stall();
    logic [17:0] expOut [3] = '{18'h11, 18'h12, 18'h0};
    logic        expVo  [3] = '{1'b1, 1'b1, 1'b0};
    logic [3:0]  expOcc [3] = '{4'd2, 4'd1, 4'd0};
    logic [17:0] tailIn [3] = '{18'h12, 18'h0, 18'h0};
    logic        tailV  [3] = '{1'b1, 1'b0, 1'b0};
    resetAll();
    inData = 18'h10; validIn = 1'b1; step();
    inData = 18'h11; validIn = 1'b1; step();
    checks++;
    if (out2 !== 18'h10 || vo2 !== 1'b1 || occ2 !== 4'd2) begin
      errors++;
      $display("[TB] FAIL stall_fill: out=%h vo=%b occ=%0d, want 10/1/2", out2, vo2, occ2);
    end
    ceIn = 1'b0; inData = 18'h99; validIn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out2 !== 18'h10 || vo2 !== 1'b1 || occ2 !== 4'd2) begin
        errors++;
        $display("[TB] FAIL stall_hold%0d: out=%h vo=%b occ=%0d, want 10/1/2", i, out2, vo2, occ2);
      end
    end
    ceIn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inData = tailIn[i]; validIn = tailV[i];
      step();
      checks++;
      if (out2 !== expOut[i] || vo2 !== expVo[i] || occ2 !== expOcc[i]) begin
        errors++;
        $display("[TB] FAIL stall_resume%0d: out=%h vo=%b occ=%0d, want %h/%b/%0d", i,
                 out2, vo2, occ2, expOut[i], expVo[i], expOcc[i]);
      end
    end
  endtask

  // DEPTH=4 full, then clear with enable and valid input both high.
  task automatic test_clear_priority();
    resetAll();
    for (int i = 0; i < 4; i++) begin
      inData = 18'h21 + 18'(i); validIn = 1'b1;
      step();
    end
    checks++;
    if (out4 !== 18'h21 || vo4 !== 1'b1 || occ4 !== 4'd4 || busy4 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clear_full: out=%h vo=%b occ=%0d busy=%b, want 21/1/4/1", out4, vo4, occ4, busy4);
    end
    clrIn = 1'b1; ceIn = 1'b1; validIn = 1'b1; inData = 18'h25;
    step();
    checks++;
    if (out4 !== 18'h15555 || vo4 !== 1'b0 || occ4 !== 4'd0 || busy4 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_prio: out=%h vo=%b occ=%0d busy=%b, want 15555/0/0/0", out4, vo4, occ4, busy4);
    end
    clrIn = 1'b0;
  endtask

  // DEPTH=2, RSTVAL=3FFFF: reset pulse between edges with two samples in flight.
  task automatic test_async_reset();
    resetAll();
    inData = 18'h101; validIn = 1'b1; step();
    inData = 18'h102; validIn = 1'b1; step();
    checks++;
    if (out2r !== 18'h101 || occ2r !== 4'd2) begin
      errors++;
      $display("[TB] FAIL areset_fill: out=%h occ=%0d, want 101/2", out2r, occ2r);
    end
    #2 rstIn = 1'b1;
    #1;
    checks++;
    if (out2r !== 18'h3FFFF || vo2r !== 1'b0 || occ2r !== 4'd0 || busy2r !== 1'b0) begin
      errors++;
      $display("[TB] FAIL areset_mid: out=%h vo=%b occ=%0d busy=%b, want 3ffff/0/0/0", out2r, vo2r, occ2r, busy2r);
    end
    #2 rstIn = 1'b0;
    inData = 18'h103; validIn = 1'b1;
    step();
    checks++;
    if (out2r !== 18'h3FFFF || vo2r !== 1'b0 || occ2r !== 4'd1) begin
      errors++;
      $display("[TB] FAIL areset_after: out=%h vo=%b occ=%0d, want 3ffff/0/1", out2r, vo2r, occ2r);
    end
  endtask

  // DEPTH=0: combinational path, reset has no effect.
  task automatic test_bypass();
    rstIn = 1'b1; inData = 18'h2AAAA; validIn = 1'b1;
    #1;
    checks++;
    if (out0 !== 18'h2AAAA || vo0 !== 1'b1 || occ0 !== 4'd0 || busy0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bypass_a: out=%h vo=%b occ=%0d busy=%b, want 2aaaa/1/0/0", out0, vo0, occ0, busy0);
    end
    inData = 18'h00155; validIn = 1'b0;
    #1;
    checks++;
    if (out0 !== 18'h00155 || vo0 !== 1'b0 || occ0 !== 4'd0) begin
      errors++;
      $display("[TB] FAIL bypass_b: out=%h vo=%b occ=%0d, want 00155/0/0", out0, vo0, occ0);
    end
    rstIn = 1'b0;
    step();
  endtask

  // DEPTH=8: twenty back-to-back valid samples; occupancy saturates at 8.
  task automatic test_back_to_back();
    logic [17:0] wantOut;
    logic        wantVo;
    logic [3:0]  wantOcc;
    resetAll();
    for (int e = 1; e <= 20; e++) begin
      inData = 18'h100 + 18'(e - 1); validIn = 1'b1;
      step();
      wantOcc = (e < 8) ? 4'(e) : 4'd8;
      wantVo  = (e >= 8);
      wantOut = (e >= 8) ? 18'h100 + 18'(e - 8) : 18'h0;
      checks++;
      if (out8 !== wantOut || vo8 !== wantVo || occ8 !== wantOcc) begin
        errors++;
        $display("[TB] FAIL stream edge%0d: out=%h vo=%b occ=%0d, want %h/%b/%0d", e,
                 out8, vo8, occ8, wantOut, wantVo, wantOcc);
      end
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_latency();
    test_stall();
    test_clear_priority();
    test_async_reset();
    test_bypass();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
